// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends a fixed PAT_W-bit pattern MSB-first, one bit per clock.
// A transmission has repeat_cnt+1 frames. Frames are separated by gap idle
// cycles, or they run back-to-back when gap is 0.
// Every output is registered and shows the state from the cycle before it.
// So the first bit appears one cycle after the state enters SHIFT, and done
// appears one cycle after the state enters DONE.
module seq_pattern_tx #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(5'b11101),
    parameter int               GAP_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             dataout,
    output logic             valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int                BCNT_W   = $clog2(PAT_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_sr;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [3:0]         r_fcnt;
    logic [GAP_W-1:0]   r_gcnt;
    logic [GAP_W-1:0]   r_gap_q;
    logic               r_dataout;
    logic               r_valid;
    logic               r_frame_start;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [PAT_W-1:0]   w_sr_nxt;
    logic [BCNT_W-1:0]  w_bcnt_nxt;
    logic [3:0]         w_fcnt_nxt;
    logic [GAP_W-1:0]   w_gcnt_nxt;
    logic [GAP_W-1:0]   w_gap_q_nxt;
    logic               w_dataout_nxt;
    logic               w_valid_nxt;
    logic               w_frame_start_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Next-state, datapath and next-output decode for the transmit FSM.
    always_comb begin
        // NOTE: every signal gets a default value first. Without it, any path
        // that skips an assignment would infer a latch.
        w_state_nxt       = r_state;
        w_sr_nxt          = r_sr;
        w_bcnt_nxt        = r_bcnt;
        w_fcnt_nxt        = r_fcnt;
        w_gcnt_nxt        = r_gcnt;
        w_gap_q_nxt       = r_gap_q;
        w_dataout_nxt     = 1'b0;
        w_valid_nxt       = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_busy_nxt        = (r_state != S_IDLE);
        w_done_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // start, repeat_cnt and gap are only sampled here.
                if (start) begin
                    w_sr_nxt    = PATTERN;
                    w_fcnt_nxt  = repeat_cnt;
                    w_gap_q_nxt = gap;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_dataout_nxt     = r_sr[PAT_W-1];
                w_valid_nxt       = 1'b1;
                w_frame_start_nxt = (r_bcnt == '0);
                w_sr_nxt          = {r_sr[PAT_W-2:0], 1'b0};
                w_bcnt_nxt        = r_bcnt + 1'b1;
                if (r_bcnt == LAST_BIT) begin
                    if (r_fcnt == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (r_gap_q == '0) begin
                        // Back-to-back: the next frame's first bit follows immediately.
                        w_fcnt_nxt = r_fcnt - 1'b1;
                        w_sr_nxt   = PATTERN;
                        w_bcnt_nxt = '0;
                    end else begin
                        w_fcnt_nxt  = r_fcnt - 1'b1;
                        w_gcnt_nxt  = r_gap_q;
                        w_state_nxt = S_GAP;
                    end
                end
            end

            S_GAP: begin
                // Counting down to 1 (rather than 0) makes the gap exactly gap_q cycles long.
                w_gcnt_nxt = r_gcnt - 1'b1;
                if (r_gcnt == GAP_W'(1)) begin
                    w_sr_nxt    = PATTERN;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with a synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its value from before the edge.
        if (!reset) begin
            r_state       <= S_IDLE;
            r_sr          <= '0;
            r_bcnt        <= '0;
            r_fcnt        <= '0;
            r_gcnt        <= '0;
            r_gap_q       <= '0;
            r_dataout     <= 1'b0;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sr          <= w_sr_nxt;
            r_bcnt        <= w_bcnt_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_gcnt        <= w_gcnt_nxt;
            r_gap_q       <= w_gap_q_nxt;
            r_dataout     <= w_dataout_nxt;
            r_valid       <= w_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign dataout     = r_dataout;
    assign valid       = r_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx. The reference model is a per-cycle list of
// expected outputs, built directly from the frame, gap and done structure.
module tb_seq_pattern_tx;

    localparam int               PAT_W = 5;
    localparam int               GAP_W = 4;
    localparam logic [PAT_W-1:0] PAT   = 5'b11101;

    // Packed view of the outputs: {dataout, valid, frame_start, busy, done}.
    typedef logic [4:0] obs_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       repeat_cnt = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             dataout;
    logic             valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    logic rx_bits[$];

    always #5 clock = ~clock;

    seq_pattern_tx #(.PAT_W(PAT_W), .PATTERN(PAT), .GAP_W(GAP_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .repeat_cnt  (repeat_cnt),
        .gap         (gap),
        .dataout     (dataout),
        .valid       (valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    // Expected outputs, one entry per cycle, starting with the cycle that
    // carries the first bit: frames, gaps, the done cycle, then one idle cycle.
    function automatic void build_expected(input int r, input int g);
        exp_q.delete();
        for (int f = 0; f <= r; f++) begin
            for (int k = 0; k < PAT_W; k++)
                exp_q.push_back({PAT[PAT_W-1-k], 1'b1, (k == 0), 1'b1, 1'b0});
            if (f < r)
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
    endfunction

    // Drive start with the given settings and let one edge sample it.
    task automatic launch(input int r, input int g);
        start      = 1'b1;
        repeat_cnt = 4'(r);
        gap        = 4'(g);
        @(posedge clock); #1;
        start      = 1'b0;
    endtask

    // Check one transmission cycle by cycle against the model, and check its busy length.
    // If hold is set, start stays high and repeat_cnt/gap are scrambled every cycle.
    // nr/ng return the settings that the edge right after done samples.
    task automatic check_txn(input int r, input int g, input bit hold, input string name,
                             output int nr, output int ng);
        int   busy_seen;
        int   n;
        obs_t got;
        busy_seen = 0;
        nr = r;
        ng = g;
        build_expected(r, g);
        n = exp_q.size();
        rx_bits.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            got = {dataout, valid, frame_start, busy, done};
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: got d/v/fs/busy/done=%b required %b",
                         name, i, got, exp_q[i]);
            end
            if (busy === 1'b1) busy_seen++;
            if (valid === 1'b1) rx_bits.push_back(dataout);
            if (hold) begin
                repeat_cnt = 4'($urandom_range(0, 3));
                gap        = 4'($urandom_range(0, 4));
                if (i == n - 2) begin
                    nr = int'(repeat_cnt);
                    ng = int'(gap);
                end
            end
        end
        checks++;
        if (busy_seen != (r + 1) * PAT_W + r * g + 1) begin
            errors++;
            $display("FAIL %s busy_len: got %0d required %0d", name, busy_seen,
                     (r + 1) * PAT_W + r * g + 1);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        obs_t got;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            got = {dataout, valid, frame_start, busy, done};
            checks++;
            if (got !== 5'b00000) begin
                errors++;
                $display("FAIL %s cycle %0d: got d/v/fs/busy/done=%b required 00000", name, i, got);
            end
        end
    endtask

    task automatic test_reset();
        int nr, ng;
        reset = 1'b0; start = 1'b1; repeat_cnt = '0; gap = '0;
        expect_quiet("reset_hold", 3);
        reset = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if ({dataout, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_edge: got d/v/busy=%b required 000", {dataout, valid, busy});
        end
        check_txn(0, 0, 1'b0, "reset_release", nr, ng);
    endtask

    task automatic test_single_frame();
        int nr, ng;
        launch(0, 7);
        check_txn(0, 7, 1'b0, "single_frame", nr, ng);
    endtask

    task automatic test_gapped();
        int nr, ng;
        launch(2, 3);
        check_txn(2, 3, 1'b0, "gapped", nr, ng);
    endtask

    task automatic test_back_to_back();
        int         nr, ng;
        int         hits;
        logic [9:0] stream;
        launch(1, 0);
        check_txn(1, 0, 1'b0, "back_to_back", nr, ng);
        stream = '0;
        for (int i = 0; i < rx_bits.size() && i < 10; i++) stream[9-i] = rx_bits[i];
        checks++;
        if (rx_bits.size() != 10 || stream !== 10'b1110111101) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bits %b required 10 bits 1110111101",
                     rx_bits.size(), stream);
        end
        hits = 0;
        for (int i = 0; i + PAT_W <= rx_bits.size(); i++) begin
            logic [PAT_W-1:0] w;
            for (int k = 0; k < PAT_W; k++) w[PAT_W-1-k] = rx_bits[i+k];
            if (w == PAT) hits++;
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL b2b_detect: got %0d hits required 2", hits);
        end
    endtask

    task automatic test_ignored_inputs();
        int nr, ng, d1, d2;
        start = 1'b1; repeat_cnt = 4'd1; gap = 4'd2;
        @(posedge clock); #1;
        check_txn(1, 2, 1'b1, "ignored_inputs", nr, ng);
        start = 1'b0;
        check_txn(nr, ng, 1'b0, "ignored_restart", d1, d2);
    endtask

    task automatic test_abort();
        int   nr, ng;
        obs_t got;
        launch(1, 2);
        build_expected(1, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            got = {dataout, valid, frame_start, busy, done};
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %b required %b", i, got, exp_q[i]);
            end
        end
        reset = 1'b0;
        expect_quiet("abort_reset", 1);
        reset = 1'b1;
        expect_quiet("abort_no_done", 8);
        launch(0, 0);
        check_txn(0, 0, 1'b0, "abort_recover", nr, ng);
    endtask

    task automatic test_random();
        int r, g, nr, ng;
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(0, 3);
            g = $urandom_range(0, 4);
            launch(r, g);
            check_txn(r, g, 1'b0, "random", nr, ng);
        end
    endtask

    task automatic test_boundary();
        int nr, ng;
        launch(15, 1);
        check_txn(15, 1, 1'b0, "max_repeat_gap1", nr, ng);
        launch(1, 15);
        check_txn(1, 15, 1'b0, "max_gap", nr, ng);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_ignored_inputs();
        test_abort();
        test_random();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
